// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and register file.
// Optional feature macro used by this slice: WB_RETIRE_CNT_EN (retired-instruction counter).
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_ADDR_W = 4;

   typedef logic [3:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   // R15 is the PC: never stored, reads return PC+8, writes redirect fetch
   localparam reg_addr_t REG_PC = 4'd15;

endpackage

// File: rtl/regfile_16x32.sv
// Architectural register file R0-R14 with one write port and two
// combinational read ports. Reads of R15 return PC+8; a read of the register
// being written this cycle returns the incoming write data.
module regfile_16x32
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wa,
   input  logic [DATA_W-1:0] i_wd,
   input  logic [ADDR_W-1:0] i_ra1,
   input  logic [ADDR_W-1:0] i_ra2,
   input  logic [DATA_W-1:0] i_pc8,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rd2
);

   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REG_PC);
   localparam int                NUM_GPR = (1 << ADDR_W) - 1;

   logic [DATA_W-1:0] r_regs [NUM_GPR];
   logic              w_we;

   // The PC slot has no storage, so a write aimed at it is dropped here too
   assign w_we = i_we && (i_wa != PC_ADDR);

   // Storage: cleared asynchronously, one write per clock
   // NOTE: every entry is reset, so this maps to flops rather than a RAM macro;
   // non-blocking assignments keep all entries updating on the same edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_GPR; i++) r_regs[i] <= '0;
      end else if (w_we) begin
         r_regs[i_wa] <= i_wd;
      end
   end

   // Read ports: PC substitution first, then write-through bypass, then storage
   // NOTE: each output gets a default before the if-chain so no latch is inferred.
   always_comb begin
      o_rd1 = '0;
      o_rd2 = '0;
      if (i_ra1 == PC_ADDR)             o_rd1 = i_pc8;
      else if (w_we && i_ra1 == i_wa)   o_rd1 = i_wd;
      else                              o_rd1 = r_regs[i_ra1];
      if (i_ra2 == PC_ADDR)             o_rd2 = i_pc8;
      else if (w_we && i_ra2 == i_wa)   o_rd2 = i_wd;
      else                              o_rd2 = r_regs[i_ra2];
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to the register file and
// raises a one-cycle-latency PC redirect for taken branches and R15 writes.
// Define WB_RETIRE_CNT_EN to add the 32-bit RetireCount output.
module wb_regfile
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ValidW,
   input  logic              RegWriteW,
   input  logic              MemtoRegW,
   input  logic              PCSrcW,
   input  logic [DATA_W-1:0] ReadDataW,
   input  logic [DATA_W-1:0] ALUResultW,
   input  logic [DATA_W-1:0] BranchResultW,
   input  logic [ADDR_W-1:0] WA3W,
   input  logic [ADDR_W-1:0] RA1D,
   input  logic [ADDR_W-1:0] RA2D,
   input  logic [DATA_W-1:0] PCPlus8D,
   output logic [DATA_W-1:0] RD1D,
   output logic [DATA_W-1:0] RD2D,
   output logic [DATA_W-1:0] ResultW,
   output logic              PCRedirectW,
   output logic [DATA_W-1:0] PCTargetW
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       RetireCount
`endif
);

   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(REG_PC);

   logic              w_wr_en;
   logic              w_pc_wr;
   logic              w_branch;
   logic              r_pc_redirect;
   logic [DATA_W-1:0] r_pc_target;

   // Result mux ignores ValidW so downstream forwarding sees it even in bubbles
   assign ResultW  = MemtoRegW ? ReadDataW : ALUResultW;
   assign w_wr_en  = ValidW & RegWriteW & (WA3W != PC_ADDR);
   assign w_pc_wr  = ValidW & RegWriteW & (WA3W == PC_ADDR);
   assign w_branch = ValidW & PCSrcW;

   regfile_16x32 #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .i_clk (clk),
      .i_rst (reset),
      .i_we  (w_wr_en),
      .i_wa  (WA3W),
      .i_wd  (ResultW),
      .i_ra1 (RA1D),
      .i_ra2 (RA2D),
      .i_pc8 (PCPlus8D),
      .o_rd1 (RD1D),
      .o_rd2 (RD2D)
   );

   // Redirect: taken branch beats an R15 write; the target holds when idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc_redirect <= 1'b0;
         r_pc_target   <= '0;
      end else if (w_branch) begin
         r_pc_redirect <= 1'b1;
         r_pc_target   <= BranchResultW;
      end else if (w_pc_wr) begin
         r_pc_redirect <= 1'b1;
         r_pc_target   <= ResultW;
      end else begin
         r_pc_redirect <= 1'b0;
      end
   end

   assign PCRedirectW = r_pc_redirect;
   assign PCTargetW   = r_pc_target;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   // Retire counter: every valid slot counts, wrapping naturally at 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_retire_cnt <= '0;
      else if (ValidW) r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign RetireCount = r_retire_cnt;
`endif

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage ARM-subset pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback result, commits it to R0–R14, and raises a registered PC redirect for taken branches and writes to R15. Provides the two decode-stage read ports with same-cycle write-through bypass, and can optionally keep a retired-instruction counter.

## Interface
Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 4, register address width (16 architectural registers; R15 = PC)

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- ValidW  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- RegWriteW  in  1  instruction writes a register
- MemtoRegW  in  1  1 = result from ReadDataW, 0 = from ALUResultW
- PCSrcW  in  1  taken branch
- ReadDataW  in  DATA_W  load data
- ALUResultW  in  DATA_W  ALU result
- BranchResultW  in  DATA_W  branch target address
- WA3W  in  ADDR_W  destination register
- RA1D, RA2D  in  ADDR_W  decode read addresses
- PCPlus8D  in  DATA_W  value returned for reads of R15
- RD1D, RD2D  out  DATA_W  decode read data
- ResultW  out  DATA_W  selected writeback value (combinational)
- PCRedirectW  out  1  registered redirect pulse
- PCTargetW  out  DATA_W  registered redirect target
- RetireCount  out  32  retired instructions (only with WB_RETIRE_CNT_EN)

## Operation
- ResultW = MemtoRegW ? ReadDataW : ALUResultW, independent of ValidW.
- wr_en = ValidW & RegWriteW & (WA3W != 15). On wr_en, regs[WA3W] <= ResultW at the clock edge.
- Redirect sources, evaluated only when ValidW=1:
  - PCSrcW=1 gives target BranchResultW.
  - RegWriteW=1 with WA3W=15 gives target ResultW.
  - If both are set, PCSrcW wins.
- On a redirect source: PCRedirectW <= 1 and PCTargetW <= target. Otherwise PCRedirectW <= 0 and PCTargetW holds its value.
- Reads:
  - RAxD = 15 returns PCPlus8D.
  - RAxD = WA3W with wr_en=1 returns ResultW (write-through bypass).
  - Otherwise returns regs[RAxD].
  - Both ports are combinational and independent; the same address on both ports is legal.
- ValidW=0 (bubble): no write, no redirect. ResultW still reflects its inputs.
- reset asserted (any time, including mid-stream): regs R0–R14 <= 0, PCRedirectW <= 0, PCTargetW <= 0, RetireCount <= 0, immediately and asynchronously. RD1D/RD2D then reflect the zeroed file (or PCPlus8D for R15). First write is accepted at the first rising edge after reset deasserts.

## Timing
- Register write: visible through regs on the cycle after the edge. Visible same-cycle via bypass.
- Redirect latency: 1 cycle. The source in cycle N gives PCRedirectW=1 in cycle N+1 for exactly one cycle, unless cycle N+1 also has a redirect source.
- Back-to-back redirects hold PCRedirectW high, with PCTargetW updated each cycle.
- No stall input. The stage accepts one instruction per clock.
- Reset outputs: RD1D/RD2D = 0 for R0–R14 addresses; ResultW is combinational; all registered outputs = 0.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - 32-bit RetireCount port exists.
  - Increments by 1 on each edge with ValidW=1, including branches and non-writing instructions.
  - Wraps 0xFFFF_FFFF → 0. Reset to 0.
- WB_RETIRE_CNT_EN undefined: port and counter logic absent; all other behaviour identical.

## Structure
- Package wb_pkg:
  - DATA_W/ADDR_W defaults
  - typedef reg_addr_t (logic [3:0])
  - typedef word_t (logic [31:0])
  - localparam REG_PC = 4'd15
- Sub-module regfile_16x32 holds:
  - the R0–R14 storage with async-reset clearing
  - the write port
  - the two read ports with R15 substitution and write-through bypass
- wb_regfile holds the result mux, the redirect flops and the optional counter.

## Test plan
- Reset: assert reset mid-stream after writing R3=0x1234 → RD1D(RA1D=3)=0 immediately; PCRedirectW=0, PCTargetW=0.
- Write/read: ValidW=1, RegWriteW=1, MemtoRegW=1, ReadDataW=0xDEADBEEF, WA3W=5, RA1D=5 → RD1D=0xDEADBEEF in the same cycle (bypass) and in the next cycle (stored).
- Bubble suppression: ValidW=0, RegWriteW=1, WA3W=2, ALUResultW=7 → R2 unchanged (0), no redirect, RetireCount unchanged.
- R15 behaviour:
  - RegWriteW=1, WA3W=15, ALUResultW=0x100 → R15 not stored; next cycle PCRedirectW=1, PCTargetW=0x100.
  - RA2D=15 → RD2D=PCPlus8D.
- Branch priority: PCSrcW=1, BranchResultW=0x200, with a simultaneous R15 write of 0x300 → next cycle PCTargetW=0x200; the following cycle, with no source, PCRedirectW=0.
- Counter (WB_RETIRE_CNT_EN): force RetireCount to 0xFFFF_FFFE, apply 3 valid cycles → 0xFFFF_FFFF, 0, 1.
